// File: rtl/can_pio_pkg.sv
`default_nettype none
// ============================================================================
// Module   : can_pio_pkg
// Purpose  : Shared register-map constants for the CAN output PIO slave
//            (system_qsys_can_out_pio) and its pulse timer.
// Revision : 1.0 - initial release
// ============================================================================
package can_pio_pkg;

  // Word addresses on the Avalon-MM slave port
  localparam logic [2:0] ADDR_DATA       = 3'd0;
  localparam logic [2:0] ADDR_RSVD1      = 3'd1;
  localparam logic [2:0] ADDR_PULSE_LEN  = 3'd2;
  localparam logic [2:0] ADDR_PULSE_TRIG = 3'd3;
  localparam logic [2:0] ADDR_OUTSET     = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR   = 3'd5;
  localparam logic [2:0] ADDR_STATUS     = 3'd6;
  localparam logic [2:0] ADDR_RSVD7      = 3'd7;

  // Bit position of the busy flag inside STATUS
  localparam int STATUS_BUSY_BIT = 0;

endpackage : can_pio_pkg
`default_nettype wire

// File: rtl/can_pio_pulse_timer.sv
`default_nettype none
// ============================================================================
// Module   : can_pio_pulse_timer
// Purpose  : One-shot pulse generator for the CAN output PIO. Holds the
//            programmed pulse length, the active pulse mask and a down
//            counter. The mask is held for exactly PULSE_LEN clocks after a
//            trigger, then released. A retrigger replaces the mask and
//            reloads the counter.
// Revision : 1.0 - initial release
// ============================================================================
module can_pio_pulse_timer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_len_we,
  input  logic [CNT_W-1:0] i_len_wdata,
  input  logic             i_trig,
  input  logic [WIDTH-1:0] i_trig_mask,
  output logic [CNT_W-1:0] o_pulse_len,
  output logic [WIDTH-1:0] o_pulse_mask,
  output logic             o_busy
);

  logic [CNT_W-1:0] r_len;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_mask;

  // Programmed pulse length; only sampled at the next trigger
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_len <= '0;
    end else if (i_len_we) begin
      r_len <= i_len_wdata;
    end
  end

  // Counter and mask: load on trigger, count down otherwise, drop mask on last count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt  <= '0;
      r_mask <= '0;
    end else if (i_trig) begin
      r_cnt  <= r_len;
      // A zero length produces no pulse at all
      r_mask <= (r_len == '0) ? '0 : i_trig_mask;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
      if (r_cnt == CNT_W'(1)) begin
        r_mask <= '0;
      end
    end
  end

  assign o_pulse_len  = r_len;
  assign o_pulse_mask = r_mask;
  assign o_busy       = (r_cnt != '0);

endmodule : can_pio_pulse_timer
`default_nettype wire

// File: rtl/system_qsys_can_out_pio.sv
`default_nettype none
// ============================================================================
// Module   : system_qsys_can_out_pio
// Purpose  : Avalon-MM output PIO driving the CAN transceiver control lines.
//            Data register with write / set / clear access, registered read
//            mux, and an optional one-shot pulse timer.
//            Build option: define CAN_PIO_PULSE_EN to include the pulse
//            timer (PULSE_LEN, PULSE_TRIG and STATUS registers). Without it
//            those registers read 0 and ignore writes.
// Revision : 1.0 - initial release
// ============================================================================
module system_qsys_can_out_pio
  import can_pio_pkg::*;
#(
  parameter int               WIDTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  logic             w_wr;
  logic             w_wr_data;
  logic             w_wr_set;
  logic             w_wr_clr;
  logic [WIDTH-1:0] w_wdata;
  logic [WIDTH-1:0] r_data;
  logic [31:0]      w_rdata;
  logic [31:0]      r_readdata;

  assign w_wr      = chipselect & ~write_n;
  assign w_wr_data = w_wr && (address == ADDR_DATA);
  assign w_wr_set  = w_wr && (address == ADDR_OUTSET);
  assign w_wr_clr  = w_wr && (address == ADDR_OUTCLEAR);
  assign w_wdata   = writedata[WIDTH-1:0];

  // Data register: plain write, bitwise set, bitwise clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data <= RESET_VALUE;
    end else if (w_wr_data) begin
      r_data <= w_wdata;
    end else if (w_wr_set) begin
      r_data <= r_data | w_wdata;
    end else if (w_wr_clr) begin
      r_data <= r_data & ~w_wdata;
    end
  end

`ifdef CAN_PIO_PULSE_EN
  logic             w_len_we;
  logic             w_trig;
  logic [CNT_W-1:0] w_pulse_len;
  logic [WIDTH-1:0] w_pulse_mask;
  logic             w_busy;

  assign w_len_we = w_wr && (address == ADDR_PULSE_LEN);
  assign w_trig   = w_wr && (address == ADDR_PULSE_TRIG);

  can_pio_pulse_timer #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_pulse_timer (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_len_we     (w_len_we),
    .i_len_wdata  (writedata[CNT_W-1:0]),
    .i_trig       (w_trig),
    .i_trig_mask  (w_wdata),
    .o_pulse_len  (w_pulse_len),
    .o_pulse_mask (w_pulse_mask),
    .o_busy       (w_busy)
  );

  // Pins come only from registers, so bus activity cannot glitch them
  assign out_port = r_data | w_pulse_mask;
`else
  assign out_port = r_data;
`endif

  // Read mux; write-only and reserved addresses return 0
  always_comb begin
    w_rdata = '0;
    case (address)
      ADDR_DATA:       w_rdata[WIDTH-1:0] = r_data;
`ifdef CAN_PIO_PULSE_EN
      ADDR_PULSE_LEN:  w_rdata[CNT_W-1:0] = w_pulse_len;
      ADDR_PULSE_TRIG: w_rdata[WIDTH-1:0] = w_pulse_mask;
      ADDR_STATUS:     w_rdata[STATUS_BUSY_BIT] = w_busy;
`endif
      default:         w_rdata = '0;
    endcase
  end

  // Registered read data, reloaded every clock regardless of chipselect
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_readdata <= '0;
    end else begin
      r_readdata <= w_rdata;
    end
  end

  assign readdata = r_readdata;

endmodule : system_qsys_can_out_pio
`default_nettype wire
